// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared instruction-memory widths, requester port indices and
//               the one-hot grant encoding used by the imem arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DATA_W = 32;

  // Requester indices into the per-port vectors
  localparam int PORT_FETCH = 0;
  localparam int PORT_DBG   = 1;

  // One-hot grant: bit PORT_FETCH / PORT_DBG set for the winning port
  typedef enum logic [1:0] {
    GNT_NONE  = 2'b00,
    GNT_FETCH = 2'b01,
    GNT_DBG   = 2'b10
  } gnt_e;

endpackage
`default_nettype wire

// File: rtl/imem_rsp_slot.sv
`default_nettype none
// ============================================================================
// Module      : imem_rsp_slot
// Description : One-entry registered response holder with valid/ready.
//               A load on the same edge as a consumer handshake replaces the
//               data and keeps valid high, giving one read per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_rsp_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              free_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Slot can take a new grant if empty or being drained this cycle
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Next state: new load wins over drain; drain alone empties the slot
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Response register, cleared asynchronously so pending data is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Shares one combinational instruction-memory read port between
//               CPU fetch (port 0) and debug readback (port 1). Grant is
//               combinational, data is registered into a per-port slot.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W   = IMEM_ADDR_W,
  parameter int DATA_W   = IMEM_DATA_W,
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
);

  logic [1:0]        w_req_valid;
  logic [1:0]        w_slot_free;
  logic [1:0]        w_elig;
  logic              w_tie_dbg;
  gnt_e              w_gnt;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;

  assign w_req_valid = {req1_valid, req0_valid};

  // No grants while reset is held, so mem_addr shows the cleared last_addr
  assign w_elig = rst_n ? (w_req_valid & w_slot_free) : 2'b00;

  // Single grant per cycle; ties resolved by the mode-specific policy below
  always_comb begin
    w_gnt = GNT_NONE;
    case (w_elig)
      2'b01:   w_gnt = GNT_FETCH;
      2'b10:   w_gnt = GNT_DBG;
      2'b11:   w_gnt = w_tie_dbg ? GNT_DBG : GNT_FETCH;
      default: w_gnt = GNT_NONE;
    endcase
  end

  assign req0_ready = w_gnt[PORT_FETCH];
  assign req1_ready = w_gnt[PORT_DBG];

  // Memory address follows the winner, otherwise parks on the last address
  always_comb begin
    mem_addr = last_addr_q;
    case (w_gnt)
      GNT_FETCH: mem_addr = req0_addr;
      GNT_DBG:   mem_addr = req1_addr;
      default:   mem_addr = last_addr_q;
    endcase
  end

  assign last_addr_d = mem_addr;

  // Remember the most recently granted address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_q <= '0;
    end else begin
      last_addr_q <= last_addr_d;
    end
  end

  generate
    if (RR_MODE != 0) begin : g_rr
      logic rr_ptr_q, rr_ptr_d;

      // Pointer flips to the other port after every grant
      always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_gnt == GNT_FETCH) begin
          rr_ptr_d = 1'b1;
        end else if (w_gnt == GNT_DBG) begin
          rr_ptr_d = 1'b0;
        end
      end

      // Round-robin pointer register, port 0 preferred out of reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rr_ptr_q <= 1'b0;
        end else begin
          rr_ptr_q <= rr_ptr_d;
        end
      end

      assign w_tie_dbg = rr_ptr_q;
    end else begin : g_fp
      localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
      localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

      logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

      // Count cycles the debug port is eligible but loses; saturate at limit
      always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req1_valid || (w_gnt == GNT_DBG)) begin
          wait_cnt_d = '0;
        end else if (w_elig[PORT_DBG] && (wait_cnt_q != WAIT_MAX)) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      // Starvation counter register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wait_cnt_q <= '0;
        end else begin
          wait_cnt_q <= wait_cnt_d;
        end
      end

      assign w_tie_dbg = (wait_cnt_q == WAIT_MAX);
    end
  endgenerate

  imem_rsp_slot #(
    .DATA_W (DATA_W)
  ) u_slot_fetch (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (w_gnt == GNT_FETCH),
    .data_i  (mem_data),
    .ready_i (rsp0_ready),
    .valid_o (rsp0_valid),
    .data_o  (rsp0_data),
    .free_o  (w_slot_free[PORT_FETCH])
  );

  imem_rsp_slot #(
    .DATA_W (DATA_W)
  ) u_slot_dbg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (w_gnt == GNT_DBG),
    .data_i  (mem_data),
    .ready_i (rsp1_ready),
    .valid_o (rsp1_valid),
    .data_o  (rsp1_data),
    .free_o  (w_slot_free[PORT_DBG])
  );

endmodule
`default_nettype wire
